// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg
//   Shared types and elaboration-time helpers for the reset sequencer.
//   - seq_state_t : sequencer FSM state encoding
//   - cnt_width() : width of the shared phase counter
//   - idx_width() : width of the stage index (at least 1 bit)
package rst_seq_pkg;

  typedef enum logic [2:0] {
    HOLD     = 3'd0,
    RELEASE  = 3'd1,
    WAIT_ACK = 3'd2,
    GAP      = 3'd3,
    DONE     = 3'd4,
    FAULT    = 3'd5
  } seq_state_t;

  // fault_stage is always reported on this many bits, zero-extended.
  localparam int FAULT_STAGE_W = 3;

  // One counter serves hold, gap and ack-timeout phases, so it is sized
  // for the largest of the three.
  function automatic int cnt_width(input int hold_c, input int gap_c, input int tmo_c);
    int m;
    m = hold_c;
    if (gap_c > m) m = gap_c;
    if (tmo_c > m) m = tmo_c;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_timer.sv
// seq_timer
//   Saturating phase counter shared by the hold, gap and ack-timeout phases.
//   The counter restarts from zero on clr and otherwise counts one per
//   cycle, sticking at all-ones instead of wrapping. last flags the cycle
//   in which the phase limit is reached, so a phase of L cycles is
//   programmed with limit = L-1.
//   Ports:
//     clk   - clock
//     clr   - synchronous clear (also used as the reset path)
//     limit - terminal count of the current phase
//     last  - high while count == limit
module seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clr)
      cnt <= '0;
    else if (cnt != '1)
      cnt <= cnt + W'(1);
  end

  assign last = (cnt == limit);

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Releases N_STAGES downstream reset domains in order (lowest index
//   first) after the system reset or a soft restart. All domains are held
//   for HOLD_CYCLES, then each stage is released, its ready acknowledge is
//   awaited (bounded by ACK_TIMEOUT), and GAP_CYCLES idle cycles separate
//   an acknowledge from the next release. A missing acknowledge parks the
//   sequencer in a sticky fault until rst or soft_req.
//   Ports:
//     clk         - clock
//     rst         - synchronous active-high reset
//     soft_req    - single-cycle restart request, accepted in any state
//     stage_ack   - per-stage ready level (clk domain)
//     stage_rstn  - per-stage active-low reset, registered, thermometer coded
//     busy        - sequence in progress
//     done        - all stages released and acknowledged
//     fault       - sticky acknowledge timeout
//     fault_stage - index of the stage that timed out (valid with fault)
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int N_STAGES    = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     soft_req,
  input  logic [N_STAGES-1:0]      stage_ack,
  output logic [N_STAGES-1:0]      stage_rstn,
  output logic                     busy,
  output logic                     done,
  output logic                     fault,
  output logic [FAULT_STAGE_W-1:0] fault_stage
);

  localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES, ACK_TIMEOUT);
  localparam int IW = idx_width(N_STAGES);

  localparam logic [IW-1:0] LAST_IDX = IW'(N_STAGES - 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LIM  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CW-1:0] TMO_LIM  = CW'(ACK_TIMEOUT - 1);

  seq_state_t    state;
  logic [IW-1:0] idx;
  logic          ack_cur;
  logic          restart;
  logic          tmr_clr;
  logic          tmr_last;
  logic [CW-1:0] tmr_limit;

  // Only the stage currently being waited on is ever looked at, so stray
  // or dropping acks of other stages have no effect.
  assign ack_cur = stage_ack[idx];
  assign restart = rst | soft_req;

  // Phase length seen by the timer in the current state.
  always_comb begin
    tmr_limit = '0;
    case (state)
      HOLD:     tmr_limit = HOLD_LIM;
      WAIT_ACK: tmr_limit = TMO_LIM;
      GAP:      tmr_limit = GAP_LIM;
      default:  tmr_limit = '0;
    endcase
  end

  // The timer restarts at every phase boundary, so each phase counts from
  // zero on its first cycle. It stays cleared in states that do not time.
  always_comb begin
    tmr_clr = 1'b1;
    case (state)
      HOLD:     tmr_clr = tmr_last;
      WAIT_ACK: tmr_clr = ack_cur | tmr_last;
      GAP:      tmr_clr = tmr_last;
      default:  tmr_clr = 1'b1;
    endcase
    if (restart) tmr_clr = 1'b1;
  end

  seq_timer #(.W(CW)) u_timer (
    .clk   (clk),
    .clr   (tmr_clr),
    .limit (tmr_limit),
    .last  (tmr_last)
  );

  // rst and soft_req share one path: both return to a full hold with
  // every stage in reset; rst having priority gives the same result.
  always_ff @(posedge clk) begin
    if (restart) begin
      state       <= HOLD;
      idx         <= '0;
      stage_rstn  <= '0;
      busy        <= 1'b1;
      done        <= 1'b0;
      fault       <= 1'b0;
      fault_stage <= '0;
    end else begin
      case (state)
        HOLD: begin
          if (tmr_last) begin
            state <= RELEASE;
            idx   <= '0;
          end
        end

        // Shifting a one in keeps stage_rstn thermometer coded by
        // construction; idx always equals the number of bits already set.
        RELEASE: begin
          stage_rstn <= (stage_rstn << 1) | N_STAGES'(1);
          state      <= WAIT_ACK;
        end

        // First look at the ack is the cycle after the release edge.
        // An ack arriving on the final timeout cycle still counts.
        WAIT_ACK: begin
          if (ack_cur) begin
            if (idx == LAST_IDX) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (GAP_CYCLES == 0) begin
              state <= RELEASE;
              idx   <= idx + IW'(1);
            end else begin
              state <= GAP;
            end
          end else if (tmr_last) begin
            state       <= FAULT;
            busy        <= 1'b0;
            fault       <= 1'b1;
            fault_stage <= FAULT_STAGE_W'(idx);
          end
        end

        GAP: begin
          if (tmr_last) begin
            state <= RELEASE;
            idx   <= idx + IW'(1);
          end
        end

        // DONE and FAULT hold all outputs until a restart.
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//   Directed, table-driven bench. Instance u_dut uses GAP_CYCLES=8 with the
//   acks following stage_rstn through a short delay line; u_dut_g0 uses
//   GAP_CYCLES=0 with acks driven directly. Table offsets are counted in
//   clock edges from the last edge that sampled rst or soft_req.
module tb_reset_sequencer;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: HOLD=16, GAP=8, TIMEOUT=255
  logic         rst, soft_req;
  logic [N-1:0] stage_ack, stage_rstn;
  logic         busy, done, fault;
  logic [2:0]   fault_stage;

  // Instance B: HOLD=16, GAP=0, TIMEOUT=255
  logic         rst_b, soft_b;
  logic [N-1:0] ack_b, rstn_b;
  logic         busy_b, done_b, fault_b;
  logic [2:0]   fault_stage_b;

  reset_sequencer #(.N_STAGES(N), .HOLD_CYCLES(16), .GAP_CYCLES(8), .ACK_TIMEOUT(255)) u_dut (
    .clk(clk), .rst(rst), .soft_req(soft_req), .stage_ack(stage_ack),
    .stage_rstn(stage_rstn), .busy(busy), .done(done), .fault(fault),
    .fault_stage(fault_stage)
  );

  reset_sequencer #(.N_STAGES(N), .HOLD_CYCLES(16), .GAP_CYCLES(0), .ACK_TIMEOUT(255)) u_dut_g0 (
    .clk(clk), .rst(rst_b), .soft_req(soft_b), .stage_ack(ack_b),
    .stage_rstn(rstn_b), .busy(busy_b), .done(done_b), .fault(fault_b),
    .fault_stage(fault_stage_b)
  );

  typedef struct {
    int           off;
    logic [N-1:0] rstn;
    logic         busy;
    logic         done;
  } vec_t;

  vec_t tbl   [12];
  vec_t tbl_b [10];

  int cyc, n_chk, n_fail;
  logic [N-1:0] d1, d2, ack_mask;

  function automatic logic therm(input logic [N-1:0] v);
    logic [N-1:0] p;
    p = v + N'(1);
    return (p & v) == '0;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Advance one edge, sample #1 later. Instance A's acks are stage_rstn
  // delayed so an ack is first seen on the third edge after its release.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    stage_ack = d2 & ~ack_mask;
    d2 = d1;
    d1 = stage_rstn;
    chk("therm_a", 8'(therm(stage_rstn)), 8'd1);
    chk("therm_b", 8'(therm(rstn_b)), 8'd1);
  endtask

  task automatic tick_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic run_table(input int base, input int upto);
    for (int k = 0; k < 12; k++) begin
      if (tbl[k].off <= upto) begin
        tick_to(base + tbl[k].off);
        chk("rstn",  8'(stage_rstn), 8'(tbl[k].rstn));
        chk("busy",  8'(busy),       8'(tbl[k].busy));
        chk("done",  8'(done),       8'(tbl[k].done));
        chk("fault", 8'(fault),      8'd0);
      end
    end
  endtask

  int base;

  initial begin
    // Full sequence with ack 2 edges behind rstn: releases at 17,29,41,53.
    tbl[0]  = '{0,  4'b0000, 1'b1, 1'b0};
    tbl[1]  = '{16, 4'b0000, 1'b1, 1'b0};
    tbl[2]  = '{17, 4'b0001, 1'b1, 1'b0};
    tbl[3]  = '{28, 4'b0001, 1'b1, 1'b0};
    tbl[4]  = '{29, 4'b0011, 1'b1, 1'b0};
    tbl[5]  = '{40, 4'b0011, 1'b1, 1'b0};
    tbl[6]  = '{41, 4'b0111, 1'b1, 1'b0};
    tbl[7]  = '{52, 4'b0111, 1'b1, 1'b0};
    tbl[8]  = '{53, 4'b1111, 1'b1, 1'b0};
    tbl[9]  = '{55, 4'b1111, 1'b1, 1'b0};
    tbl[10] = '{56, 4'b1111, 1'b0, 1'b1};
    tbl[11] = '{60, 4'b1111, 1'b0, 1'b1};
    // GAP=0 with acks already high: one bit every 2 edges.
    tbl_b[0] = '{16, 4'b0000, 1'b1, 1'b0};
    tbl_b[1] = '{17, 4'b0001, 1'b1, 1'b0};
    tbl_b[2] = '{18, 4'b0001, 1'b1, 1'b0};
    tbl_b[3] = '{19, 4'b0011, 1'b1, 1'b0};
    tbl_b[4] = '{20, 4'b0011, 1'b1, 1'b0};
    tbl_b[5] = '{21, 4'b0111, 1'b1, 1'b0};
    tbl_b[6] = '{22, 4'b0111, 1'b1, 1'b0};
    tbl_b[7] = '{23, 4'b1111, 1'b1, 1'b0};
    tbl_b[8] = '{24, 4'b1111, 1'b0, 1'b1};
    tbl_b[9] = '{27, 4'b1111, 1'b0, 1'b1};

    cyc = 0; n_chk = 0; n_fail = 0;
    d1 = '0; d2 = '0; ack_mask = '0; stage_ack = '0;
    rst = 1'b1; soft_req = 1'b1;
    rst_b = 1'b1; soft_b = 1'b0; ack_b = '0;

    // Reset with a coincident soft_req: reset state.
    tick();
    chk("rst_rstn",   8'(stage_rstn),  8'h00);
    chk("rst_busy",   8'(busy),        8'd1);
    chk("rst_done",   8'(done),        8'd0);
    chk("rst_fault",  8'(fault),       8'd0);
    chk("rst_fstage", 8'(fault_stage), 8'd0);
    soft_req = 1'b0;
    tick();

    // 1. Power-up sequence.
    base = cyc; rst = 1'b0;
    run_table(base, 1000);

    // 3a. soft_req in DONE: immediate 0000, full hold, completes.
    soft_req = 1'b1; tick(); soft_req = 1'b0;
    base = cyc;
    run_table(base, 1000);

    // 3b. soft_req in GAP after stage 1 ack (gap spans offsets 33..40).
    soft_req = 1'b1; tick(); soft_req = 1'b0;
    base = cyc;
    run_table(base, 29);
    tick_to(base + 34);
    soft_req = 1'b1; tick(); soft_req = 1'b0;
    base = cyc;
    run_table(base, 1000);

    // 4. rst during WAIT_ACK of stage 1 (offsets 30..32).
    soft_req = 1'b1; tick(); soft_req = 1'b0;
    base = cyc;
    run_table(base, 29);
    tick_to(base + 30);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rstmid_rstn",  8'(stage_rstn), 8'h00);
    chk("rstmid_busy",  8'(busy),       8'd1);
    chk("rstmid_fault", 8'(fault),      8'd0);
    base = cyc;
    run_table(base, 1000);

    // 2. Timeout on stage 2: released at +41, fault at +41+255.
    ack_mask = 4'b0100;
    soft_req = 1'b1; tick(); soft_req = 1'b0;
    base = cyc;
    run_table(base, 41);
    tick_to(base + 295);
    chk("tmo_pre_fault", 8'(fault),      8'd0);
    chk("tmo_pre_busy",  8'(busy),       8'd1);
    chk("tmo_pre_rstn",  8'(stage_rstn), 8'h07);
    tick();
    chk("tmo_fault",  8'(fault),       8'd1);
    chk("tmo_fstage", 8'(fault_stage), 8'd2);
    chk("tmo_busy",   8'(busy),        8'd0);
    chk("tmo_done",   8'(done),        8'd0);
    chk("tmo_rstn",   8'(stage_rstn),  8'h07);

    // 6. Late ack does not leave FAULT; soft_req recovers.
    ack_mask = '0;
    tick_to(base + 303);
    chk("flt_hold_fault", 8'(fault),      8'd1);
    chk("flt_hold_rstn",  8'(stage_rstn), 8'h07);
    chk("flt_hold_done",  8'(done),       8'd0);
    soft_req = 1'b1; tick(); soft_req = 1'b0;
    chk("rec_fault",  8'(fault),       8'd0);
    chk("rec_fstage", 8'(fault_stage), 8'd0);
    base = cyc;
    run_table(base, 1000);

    // 5. GAP_CYCLES=0, acks high before the sequence starts.
    ack_b = 4'b1111;
    base = cyc; rst_b = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick_to(base + tbl_b[k].off);
      chk("g0_rstn", 8'(rstn_b), 8'(tbl_b[k].rstn));
      chk("g0_busy", 8'(busy_b), 8'(tbl_b[k].busy));
      chk("g0_done", 8'(done_b), 8'(tbl_b[k].done));
    end

    // Stray ack[3] while waiting on stage 0 must not advance anything.
    ack_b = 4'b1000;
    soft_b = 1'b1; tick(); soft_b = 1'b0;
    base = cyc;
    chk("g0s_rstn0", 8'(rstn_b), 8'h00);
    tick_to(base + 17);
    chk("g0s_rel0", 8'(rstn_b), 8'h01);
    tick_to(base + 30);
    chk("g0s_stuck", 8'(rstn_b), 8'h01);
    chk("g0s_busy",  8'(busy_b), 8'd1);
    ack_b = 4'b1111;
    tick_to(base + 32);
    chk("g0s_r1", 8'(rstn_b), 8'h03);
    tick_to(base + 34);
    chk("g0s_r2", 8'(rstn_b), 8'h07);
    tick_to(base + 36);
    chk("g0s_r3",    8'(rstn_b), 8'h0f);
    chk("g0s_ndone", 8'(done_b), 8'd0);
    tick_to(base + 37);
    chk("g0s_done",   8'(done_b),        8'd1);
    chk("g0s_fault",  8'(fault_b),       8'd0);
    chk("g0s_fstage", 8'(fault_stage_b), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
